// File: rtl/target_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// target_ctrl_pkg
//   Shared definitions for the target controller: FSM state encoding and the
//   default ON_TICKS / SCORE_W values used by target_ctrl.
//
//   Contents:
//     DEF_ON_TICKS  default number of ticks a target stays lit (legal 1..15)
//     DEF_SCORE_W   default width of the score counter
//     CNT_W         width of the lit-time tick counter (holds up to 15)
//     state_t       IDLE / LIT / COOL state encoding
// ----------------------------------------------------------------------------
package target_ctrl_pkg;

    localparam int DEF_ON_TICKS = 4;
    localparam int DEF_SCORE_W  = 8;
    localparam int CNT_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LIT  = 2'd1,
        ST_COOL = 2'd2
    } state_t;

endpackage

// File: rtl/target_ctrl_rise_detect.sv
// ----------------------------------------------------------------------------
// rise_detect
//   Rising-edge detector for an already-synchronised level input.
//
//   Ports:
//     clk   input   system clock
//     rst   input   asynchronous active-high reset
//     in    input   level input (button)
//     rise  output  high for the cycle where in==1 and the previous cycle's
//                   in==0
//
//   After reset the detector needs one clock of history before it may fire,
//   so a level that is already high when reset releases never counts as an
//   edge. The input has to drop and rise again.
// ----------------------------------------------------------------------------
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic hist;
    logic armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist  <= 1'b0;
            armed <= 1'b0;
        end else begin
            hist  <= in;
            armed <= 1'b1;
        end
    end

    assign rise = in & ~hist & armed;

endmodule

// File: rtl/target_ctrl.sv
// ----------------------------------------------------------------------------
// target_ctrl
//   Reaction-game target controller. On a slow tick, a random bit decides
//   whether a target lights. While lit, a button press scores a hit; if
//   ON_TICKS ticks pass without a press, the target expires with a miss.
//   After either outcome the controller cools down for one tick before it
//   can light again.
//
//   Parameters:
//     ON_TICKS    ticks a target stays lit (1..15)
//     SCORE_W     score counter width
//
//   Ports:
//     clk         input   system clock
//     rst         input   asynchronous active-high reset
//     slowenable  input   one-clk tick pulse (also advances the upstream LFSR)
//     rout        input   pseudo-random bit from the LFSR
//     btn         input   player button, synchronised level
//     led         output  target lit (registered)
//     hit         output  one-clk pulse on a successful press
//     miss        output  one-clk pulse when a lit target expires
//     score       output  running score, saturating at all-ones
//
//   Build option:
//     TARGET_PENALTY_EN  when defined, a press while IDLE costs one point
//                        (saturating at zero); otherwise such presses are
//                        ignored.
//
//   State | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting; each tick samples rout, rout==1 lights the target
//   LIT   | target lit; press -> hit, ON_TICKS ticks without press -> miss
//   COOL  | outcome done; next tick returns to IDLE without sampling rout
// ----------------------------------------------------------------------------
module target_ctrl
    import target_ctrl_pkg::*;
#(
    parameter int ON_TICKS = DEF_ON_TICKS,
    parameter int SCORE_W  = DEF_SCORE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               slowenable,
    input  logic               rout,
    input  logic               btn,
    output logic               led,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score
);

    localparam logic [CNT_W-1:0]   LAST_TICK = CNT_W'(ON_TICKS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             tick_d;
    logic             press;

    // rout is only valid one clock after slowenable, once the LFSR has
    // stepped, so every tick-driven decision uses the delayed pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_d <= 1'b0;
        end else begin
            tick_d <= slowenable;
        end
    end

    rise_detect u_rise_detect (
        .clk  (clk),
        .rst  (rst),
        .in   (btn),
        .rise (press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            led   <= 1'b0;
            hit   <= 1'b0;
            miss  <= 1'b0;
            score <= '0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tick_d && rout) begin
                        state <= ST_LIT;
                        led   <= 1'b1;
                        cnt   <= '0;
                    end
`ifdef TARGET_PENALTY_EN
                    if (press && (score != '0)) begin
                        score <= score - SCORE_W'(1);
                    end
`endif
                end

                ST_LIT: begin
                    // A press takes priority over an expiring tick in the
                    // same cycle, so hit and miss can never coincide.
                    if (press) begin
                        hit   <= 1'b1;
                        state <= ST_COOL;
                        led   <= 1'b0;
                        if (score != SCORE_MAX) begin
                            score <= score + SCORE_W'(1);
                        end
                    end else if (tick_d) begin
                        if (cnt == LAST_TICK) begin
                            miss  <= 1'b1;
                            state <= ST_COOL;
                            led   <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                ST_COOL: begin
                    if (tick_d) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    led   <= 1'b0;
                end
            endcase
        end
    end

endmodule
